mem_wb_stage: RTL

Memory-access stage of the five-stage RISC-V pipeline, merged with the MEM/WB pipeline register. It consumes the EX/MEM latch outputs, performs word stores and word/unsigned-byte loads against an internal data RAM, and selects the write-back value. It executes `ecall` side effects (display, halt) and keeps cycle/retire statistics. Registered results feed the write-back mux and the bypass network.

---
 rtl/mem_wb_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access stage merged with the MEM/WB register: data RAM, load alignment, write-back select,
// ecall side effects (display/halt) and cycle/retire counters. Display ecall enabled by SYSCALL_DISPLAY_EN.
module mem_wb_stage #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             RegWrite_in,
    input  logic             MemToReg_in,
    input  logic             MemWrite_in,
    input  logic             LBU_in,
    input  logic             ecall_in,
    input  logic [4:0]       WriteRegNo_in,
    input  logic [WIDTH-1:0] PC_in,
    input  logic [WIDTH-1:0] IR_in,
    input  logic [WIDTH-1:0] WriteData_in,
    input  logic [WIDTH-1:0] Result_in,
    input  logic [WIDTH-1:0] a0_in,
    input  logic [WIDTH-1:0] a7_in,
    output logic             RegWrite_out,
    output logic [4:0]       WriteRegNo_out,
    output logic [WIDTH-1:0] WBData_out,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] IR_out,
    output logic             halt,
    output logic [WIDTH-1:0] disp,
    output logic [WIDTH-1:0] cycle_cnt,
    output logic [WIDTH-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]     mem [0:(1<<ADDR_BITS)-1];
    logic [ADDR_BITS-1:0] word_addr;
    logic [WIDTH-1:0]     load_word;
    logic [WIDTH-1:0]     wb_next;
    logic                 active;
    logic                 store_en;
    logic                 ecall_ok;
    logic                 halt_req;

    logic             reg_write_p1;
    logic [4:0]       write_reg_p1;
    logic [WIDTH-1:0] wb_data_p1;
    logic [WIDTH-1:0] pc_p1;
    logic [WIDTH-1:0] ir_p1;
    logic [WIDTH-1:0] cycle_q;
    logic [WIDTH-1:0] retire_q;
    logic [WIDTH-1:0] disp_q;

    function automatic logic [WIDTH-1:0] load_align(input logic [WIDTH-1:0] word,
                                                    input logic [1:0]       sel,
                                                    input logic             lbu);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return lbu ? {{(WIDTH-8){1'b0}}, b} : word;
    endfunction

    assign word_addr = Result_in[ADDR_BITS+1:2];
    assign active    = en && (state == RUN);
    assign store_en  = MemWrite_in && active;
    assign ecall_ok  = ecall_in && active;
    assign halt_req  = ecall_ok && (a7_in == WIDTH'(10));

    // Asynchronous read sees the pre-store contents when load and store hit the same word.
    assign load_word = mem[word_addr];
    assign wb_next   = MemToReg_in ? load_align(load_word, Result_in[1:0], LBU_in) : Result_in;

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halt_req) state_next = DRAIN;
            DRAIN:   state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    // A store coinciding with an asserted reset is dropped.
    always_ff @(posedge clk) begin
        if (store_en && rst) mem[word_addr] <= WriteData_in;
    end

    // MEM -> WB register boundary (p1)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_p1 <= 1'b0;
            write_reg_p1 <= '0;
            wb_data_p1   <= '0;
            pc_p1        <= '0;
            ir_p1        <= '0;
        end else if (state != RUN) begin
            reg_write_p1 <= 1'b0;
            write_reg_p1 <= '0;
            wb_data_p1   <= '0;
            pc_p1        <= '0;
            ir_p1        <= '0;
        end else if (en) begin
            reg_write_p1 <= RegWrite_in;
            write_reg_p1 <= WriteRegNo_in;
            wb_data_p1   <= wb_next;
            pc_p1        <= PC_in;
            ir_p1        <= IR_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            if (state == RUN)               cycle_q  <= cycle_q + WIDTH'(1);
            if (active && (IR_in != '0))    retire_q <= retire_q + WIDTH'(1);
        end
    end

`ifdef SYSCALL_DISPLAY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  disp_q <= '0;
        else if (ecall_ok && a7_in == WIDTH'(34))  disp_q <= a0_in;
    end
`else
    logic unused_a0;
    assign unused_a0 = ^a0_in;
    assign disp_q    = '0;
`endif

    assign RegWrite_out   = reg_write_p1;
    assign WriteRegNo_out = write_reg_p1;
    assign WBData_out     = wb_data_p1;
    assign PC_out         = pc_p1;
    assign IR_out         = ir_p1;
    assign halt           = (state != RUN);
    assign disp           = disp_q;
    assign cycle_cnt      = cycle_q;
    assign retire_cnt     = retire_q;

endmodule
